// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: program-counter controller state and reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_pkg;

  // The PC is loaded with this address when reset_n is low.
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  // ST_RUN    : normal sequential fetch
  // ST_DELAY  : delay-slot instruction is current; the captured target is pending
  // ST_HALTED : a transfer to address 0 completed; the CPU has stopped
  // ST_FAULT  : a transfer to a misaligned address completed; only reset leaves this state
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DELAY  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/mips_cpu_target_calc.sv
// Control-transfer target calculator: register, jump-field or branch-offset target.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   pc          current instruction address
//   immediate   16-bit branch offset, in instruction words
//   instr_index 26-bit j/jal target field
//   rs_content  register target for jr/jalr
//   sel_reg     jr/jalr is decoded (highest priority)
//   sel_jump    j/jal is decoded (beats a conditional branch)
//   target      selected transfer target
module mips_cpu_target_calc
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] immediate,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_content,
  input  logic        sel_reg,
  input  logic        sel_jump,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  // Sign-extend the word offset and scale it to bytes. The addition wraps modulo 2^32.
  assign branch_offset = {{14{immediate[15]}}, immediate, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  // j/jal stays inside the 256 MB region that holds the delay slot.
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

  always_comb begin
    target = branch_target;
    if (sel_reg) begin
      target = rs_content;
    end else if (sel_jump) begin
      target = jump_target;
    end
  end

endmodule

// File: rtl/mips_cpu_pc_ctrl.sv
// MIPS program-counter controller with a branch delay slot, halt-on-zero and misalignment fault.
// Latency: pc updates 1 cycle after an advance; a transfer takes effect after the delay slot retires.
// Backpressure: advance=0 freezes pc, state and the pending target. HALTED and FAULT ignore advance.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   advance             current instruction retires this cycle
//   sig_branch, link    conditional branch taken / branch-and-link request, from the ALU
//   is_j .. is_jalr     decoded jump instructions
//   instr_index, immediate, rs_content, rd_index   target and link operands
//   pc                  current instruction address
//   link_we, link_dest, link_addr   register-file link write (link value is pc+8)
//   active, fault       CPU running / misaligned-target fault
module mips_cpu_pc_ctrl
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        sig_branch,
  input  logic        link,
  input  logic        is_j,
  input  logic        is_jal,
  input  logic        is_jr,
  input  logic        is_jalr,
  input  logic [25:0] instr_index,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_content,
  input  logic [4:0]  rd_index,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [4:0]  link_dest,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        fault
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        transfer;

  assign pc_plus4 = pc_q + 32'd4;
  assign transfer = sig_branch | is_j | is_jal | is_jr | is_jalr;

  mips_cpu_target_calc u_target_calc (
    .pc          (pc_q),
    .immediate   (immediate),
    .instr_index (instr_index),
    .rs_content  (rs_content),
    .sel_reg     (is_jr | is_jalr),
    .sel_jump    (is_j | is_jal),
    .target      (target)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    case (state_q)
      ST_RUN: begin
        if (advance) begin
          pc_d = pc_plus4;
          if (transfer) begin
            target_d = target;
            state_d  = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        // The delay slot always retires. A transfer decoded in the slot does not
        // retarget; its link write still happens through link_we below.
        if (advance) begin
          if (target_q == 32'h0) begin
            pc_d    = 32'h0;
            state_d = ST_HALTED;
          end else if (target_q[1:0] != 2'b00) begin
            // pc is left at the delay-slot address so the faulting point is visible.
            state_d = ST_FAULT;
          end else begin
            pc_d    = target_q;
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        // ST_HALTED and ST_FAULT hold everything until reset.
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
    end
  end

  assign pc        = pc_q;
  assign active    = (state_q == ST_RUN) || (state_q == ST_DELAY);
  assign fault     = (state_q == ST_FAULT);
  // reset_n gates the write so nothing reaches the register file while reset is held.
  assign link_we   = advance & (link | is_jal | is_jalr) & active & reset_n;
  assign link_dest = is_jalr ? rd_index : 5'd31;
  assign link_addr = pc_q + 32'd8;

endmodule

// File: doc/mips_cpu_pc_ctrl.md
MIPS_CPU_PC_CTRL -- requirements
Module: mips_cpu_pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port advance, input, 1, current instruction retires this cycle (fetch valid, no stall).
REQ-005 SHALL have port sig_branch, input, 1, conditional branch taken, from the ALU.
REQ-006 SHALL have port link, input, 1, branch-and-link request (bltzal/bgezal), from the ALU.
REQ-007 SHALL have port is_j, input, 1, j instruction.
REQ-008 SHALL have port is_jal, input, 1, jal instruction.
REQ-009 SHALL have port is_jr, input, 1, jr instruction.
REQ-010 SHALL have port is_jalr, input, 1, jalr instruction.
REQ-011 SHALL have port instr_index, input, 26, j/jal target field.
REQ-012 SHALL have port immediate, input, 16, branch offset field.
REQ-013 SHALL have port rs_content, input, 32, register target for jr/jalr.
REQ-014 SHALL have port rd_index, input, 5, jalr link destination.
REQ-015 SHALL have port pc, output, 32, address of the current instruction.
REQ-016 SHALL have port link_we, output, 1, register-file write enable for the link value.
REQ-017 SHALL have port link_dest, output, 5, link destination register.
REQ-018 SHALL have port link_addr, output, 32, link value, equal to pc+8.
REQ-019 SHALL have port active, output, 1, CPU running.
REQ-020 SHALL have port fault, output, 1, misaligned control-transfer target.

Function
REQ-021 SHALL implement states RUN, DELAY, HALTED and FAULT.
REQ-022 When advance=0, pc, state and captured target SHALL hold.
REQ-023 In RUN with advance=1 and a transfer (sig_branch|is_j|is_jal|is_jr|is_jalr), the block SHALL capture the target, set pc<=pc+4 and enter DELAY.
REQ-024 In RUN with advance=1 and no transfer, the block SHALL set pc<=pc+4.
REQ-025 In DELAY with advance=1, the block SHALL set pc<=target and return to RUN.
REQ-026 The delay-slot instruction SHALL always execute.
REQ-027 A transfer arriving in DELAY SHALL be ignored for targeting; its link write SHALL still occur.
REQ-028 Branch target SHALL be pc+4+(sign-extended immediate<<2), computed modulo 2^32.
REQ-029 j/jal target SHALL be {(pc+4)[31:28], instr_index, 2'b00}.
REQ-030 jr/jalr target SHALL be rs_content.
REQ-031 Transfer priority SHALL be jr/jalr > j/jal > sig_branch.
REQ-032 link_we SHALL be combinational: advance & (link|is_jal|is_jalr) & active.
REQ-033 link_dest SHALL be rd_index for jalr and 5'd31 otherwise.
REQ-034 A captured target of 32'h0 SHALL enter HALTED, not RUN, on leaving DELAY; pc then holds 0.
REQ-035 In HALTED, active SHALL be 0 and advance SHALL be ignored.
REQ-036 A captured target with [1:0]!=0 SHALL enter FAULT on leaving DELAY.
REQ-037 In FAULT, fault=1, active=0, pc holds, and the state SHALL be left only by reset.

Reset
REQ-038 reset_n=0 SHALL immediately force pc=RESET_VECTOR, state RUN, target 0, active=1, fault=0, link_we=0.
REQ-039 Reset asserted mid-DELAY SHALL discard the pending target.

Structure
REQ-040 The state enum and RESET_VECTOR default SHALL reside in the shared package mips_cpu_pkg.
REQ-041 Target arithmetic SHALL be a combinational sub-module mips_cpu_target_calc (pc, immediate, instr_index, rs_content, selects -> target).

Verification
REQ-042 Reset then 3 advances with no transfer -> pc = BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-043 At pc=BFC00010, beq taken with immediate=16'hFFFC -> pc BFC00014 (delay slot), then BFC00004.
REQ-044 jal at BFC00020 with instr_index=26'h0000100 -> link_we=1, link_dest=31, link_addr=BFC00028; pc BFC00024, then B0000400.
REQ-045 jr with rs=0, then advance over delay slot -> active=0 and pc=0; further advances leave pc unchanged.
REQ-046 jalr rd=5 with rs=BFC00102, then advance -> link_dest=5 in the jr cycle; fault=1 and active=0 after the delay slot.
REQ-047 advance held 0 for 4 cycles in DELAY, then reset_n pulsed low -> pc holds during the stall, then becomes BFC00000 asynchronously in state RUN.
